// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and types for the audio-in capture path
package audio_pkg;
  localparam int AUDIO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH       = 128;
  localparam int FILL_WIDTH       = 8;
  localparam int SYNC_STAGES      = 2;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;
endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - single-clock show-ahead sample FIFO with fill count
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH  = AUDIO_DATA_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int FILL_W = FILL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_push_data,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_head,
  output logic              o_full,
  output logic [FILL_W-1:0] o_fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_empty = (r_fill == '0);
  assign o_full  = (r_fill == FULL_CNT);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~w_empty;
  assign o_fill  = r_fill;
  // Head reads zero rather than stale storage while empty, so reset/clear show 0.
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end
endmodule

// File: rtl/audio_in_deserializer.sv
// rtl/audio_in_deserializer.sv - left-justified ADC capture into paired L/R sample FIFOs
module audio_in_deserializer
  import audio_pkg::*;
(
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_ADCLRCK,
  input  logic                        AUD_ADCDAT,
  input  logic                        clear_audio_in_memory,
  input  logic                        read_audio_in,
  output logic                        audio_in_available,
  output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
  output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
  output logic [FILL_WIDTH-1:0]       left_fill,
  output logic [FILL_WIDTH-1:0]       right_fill,
  output logic                        audio_in_overflow
);
  localparam int IDX_W = $clog2(AUDIO_DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(AUDIO_DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0]      r_bclk_sync;
  logic [SYNC_STAGES-1:0]      r_lr_sync;
  logic [SYNC_STAGES-1:0]      r_dat_sync;
  logic                        r_bclk_prev;
  logic                        r_lr_prev;
  logic [SYNC_STAGES:0]        r_warm;
  logic                        r_sync_done;
  logic                        r_capture_en;
  logic                        r_left_valid;
  channel_e                    r_channel;
  logic [IDX_W-1:0]            r_bit_idx;
  logic [AUDIO_DATA_WIDTH-1:0] r_shift;
  logic [AUDIO_DATA_WIDTH-1:0] r_left_pend;

  logic w_bclk_rise, w_lr_rise, w_lr_fall, w_dat_s, w_edge_ok;
  logic w_open_new, w_push, w_push_ok, w_pop, w_left_full, w_right_full;
  logic [FILL_WIDTH-1:0] w_left_next, w_right_next;

  // Edges are masked until the history register holds a real sample, so a
  // line already high when reset releases is not mistaken for a rising edge.
  assign w_edge_ok   = r_warm[SYNC_STAGES];
  assign w_bclk_rise = w_edge_ok & r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
  assign w_lr_rise   = w_edge_ok & r_lr_sync[SYNC_STAGES-1] & ~r_lr_prev;
  assign w_lr_fall   = w_edge_ok & ~r_lr_sync[SYNC_STAGES-1] & r_lr_prev;
  assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];

  assign w_open_new = w_lr_rise | (w_lr_fall & r_sync_done);
  assign w_push     = w_lr_rise & r_sync_done & (r_channel == CH_RIGHT) & r_left_valid;
  assign w_push_ok  = w_push & ~w_left_full & ~w_right_full;
  assign w_pop      = read_audio_in & audio_in_available;

  assign w_left_next  = left_fill + FILL_WIDTH'(w_push_ok) - FILL_WIDTH'(w_pop);
  assign w_right_next = right_fill + FILL_WIDTH'(w_push_ok) - FILL_WIDTH'(w_pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
      r_lr_prev   <= 1'b0;
      r_warm      <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      r_bclk_prev <= r_bclk_sync[SYNC_STAGES-1];
      r_lr_prev   <= r_lr_sync[SYNC_STAGES-1];
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync_done  <= 1'b0;
      r_capture_en <= 1'b0;
      r_left_valid <= 1'b0;
      r_channel    <= CH_LEFT;
      r_bit_idx    <= IDX_MSB;
      r_shift      <= '0;
      r_left_pend  <= '0;
    end else if (clear_audio_in_memory) begin
      r_sync_done  <= 1'b0;
      r_capture_en <= 1'b0;
      r_left_valid <= 1'b0;
      r_channel    <= CH_LEFT;
      r_bit_idx    <= IDX_MSB;
      r_shift      <= '0;
      r_left_pend  <= '0;
    end else if (w_open_new) begin
      r_sync_done  <= 1'b1;
      r_capture_en <= 1'b1;
      r_channel    <= w_lr_rise ? CH_LEFT : CH_RIGHT;
      if (w_lr_fall && r_channel == CH_LEFT) begin
        r_left_pend  <= r_shift;
        r_left_valid <= 1'b1;
      end else if (w_lr_rise) begin
        r_left_valid <= 1'b0;
      end
      // A bit arriving with the frame edge is the MSB of the new word.
      if (w_bclk_rise) begin
        r_shift   <= {w_dat_s, {(AUDIO_DATA_WIDTH-1){1'b0}}};
        r_bit_idx <= IDX_MSB - 1'b1;
      end else begin
        r_shift   <= '0;
        r_bit_idx <= IDX_MSB;
      end
    end else if (w_bclk_rise && r_capture_en) begin
      r_shift[r_bit_idx] <= w_dat_s;
      if (r_bit_idx == '0) r_capture_en <= 1'b0;
      else                 r_bit_idx    <= r_bit_idx - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      audio_in_available <= 1'b0;
      audio_in_overflow  <= 1'b0;
    end else if (clear_audio_in_memory) begin
      audio_in_available <= 1'b0;
      audio_in_overflow  <= 1'b0;
    end else begin
      audio_in_available <= (w_left_next != '0) && (w_right_next != '0);
      if (w_push && !w_push_ok) audio_in_overflow <= 1'b1;
    end
  end

  audio_sample_fifo u_left_fifo (
    .clk         (CLOCK_50),
    .rst         (reset),
    .i_clear     (clear_audio_in_memory),
    .i_push      (w_push_ok),
    .i_push_data (r_left_pend),
    .i_pop       (w_pop),
    .o_head      (left_channel_audio_in),
    .o_full      (w_left_full),
    .o_fill      (left_fill)
  );

  audio_sample_fifo u_right_fifo (
    .clk         (CLOCK_50),
    .rst         (reset),
    .i_clear     (clear_audio_in_memory),
    .i_push      (w_push_ok),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (right_channel_audio_in),
    .o_full      (w_right_full),
    .o_fill      (right_fill)
  );
endmodule
